// File: rtl/ibuf_rx_filter.sv
// rtl/ibuf_rx_filter.sv - synchronizing, turnaround-blanked, glitch-filtered receiver for a bidirectional pad
//
// Ports:
//   C      clock, all flops rising-edge
//   R      synchronous active-high reset
//   I      pad-side line level, asynchronous to C
//   T      local tristate control (0 = local driver active, 1 = released)
//   O      filtered received level
//   VALID  high while the receiver is in RECV
//   RISE   one-cycle pulse when O goes 0->1
//   FALL   one-cycle pulse when O goes 1->0
//   GLITCH one-cycle pulse when a level change is rejected by the filter

module ibuf_rx_filter #(
    parameter int   FILTER_LEN = 3,
    parameter int   TURN       = 2,
    parameter logic INIT       = 1'b0
) (
    input  logic C,
    input  logic R,
    input  logic I,
    input  logic T,
    output logic O,
    output logic VALID,
    output logic RISE,
    output logic FALL,
    output logic GLITCH
);

    typedef enum logic [1:0] {
        ST_DRIVE = 2'd0,
        ST_TURN  = 2'd1,
        ST_RECV  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST  = 4'(FILTER_LEN - 1);
    localparam logic [3:0] TCNT_LAST = 4'(TURN - 1);

    state_t     state_q, state_d;
    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       o_q, o_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] tcnt_q, tcnt_d;
    logic       valid_q, valid_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic       glitch_q, glitch_d;

    always_comb begin
        // The synchronizer runs in every state so s2 is current on RECV entry.
        s1_d     = I;
        s2_d     = s1_q;
        state_d  = state_q;
        o_d      = o_q;
        cnt_d    = cnt_q;
        tcnt_d   = tcnt_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;

        case (state_q)
            ST_DRIVE: begin
                cnt_d = 4'd0;
                if (T) begin
                    state_d = ST_TURN;
                    tcnt_d  = 4'd0;
                end
            end
            ST_TURN: begin
                cnt_d = 4'd0;
                if (!T) begin
                    state_d = ST_DRIVE;
                    tcnt_d  = 4'd0;
                end else if (tcnt_q == TCNT_LAST) begin
                    // Line has settled: adopt its level silently, no edge pulse.
                    state_d = ST_RECV;
                    o_d     = s2_q;
                    tcnt_d  = 4'd0;
                end else begin
                    tcnt_d = tcnt_q + 4'd1;
                end
            end
            ST_RECV: begin
                if (!T) begin
                    state_d = ST_DRIVE;
                    cnt_d   = 4'd0;
                end else if (s2_q != o_q) begin
                    if (cnt_q >= CNT_LAST) begin
                        o_d    = s2_q;
                        cnt_d  = 4'd0;
                        rise_d = s2_q;
                        fall_d = ~s2_q;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (cnt_q != 4'd0) begin
                    // Line returned to O before the new level was held long enough.
                    glitch_d = 1'b1;
                    cnt_d    = 4'd0;
                end
            end
            default: begin
                state_d = ST_DRIVE;
                cnt_d   = 4'd0;
                tcnt_d  = 4'd0;
            end
        endcase

        valid_d = (state_d == ST_RECV);
    end

    always_ff @(posedge C) begin
        if (R) begin
            state_q  <= ST_DRIVE;
            s1_q     <= INIT;
            s2_q     <= INIT;
            o_q      <= INIT;
            cnt_q    <= 4'd0;
            tcnt_q   <= 4'd0;
            valid_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            o_q      <= o_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            valid_q  <= valid_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign O      = o_q;
    assign VALID  = valid_q;
    assign RISE   = rise_q;
    assign FALL   = fall_q;
    assign GLITCH = glitch_q;

endmodule

// File: tb/tb_ibuf_rx_filter.sv
// tb/tb_ibuf_rx_filter.sv - scoreboard bench for ibuf_rx_filter, default and FILTER_LEN=1/TURN=1/INIT=1 instances

module tb_ibuf_rx_filter;

    logic C = 1'b0;
    logic R = 1'b1;
    logic T = 1'b1;
    logic I = 1'b0;

    logic o_a, valid_a, rise_a, fall_a, glitch_a;
    logic o_b, valid_b, rise_b, fall_b, glitch_b;

    ibuf_rx_filter dut_a (
        .C      (C),
        .R      (R),
        .I      (I),
        .T      (T),
        .O      (o_a),
        .VALID  (valid_a),
        .RISE   (rise_a),
        .FALL   (fall_a),
        .GLITCH (glitch_a)
    );

    ibuf_rx_filter #(
        .FILTER_LEN (1),
        .TURN       (1),
        .INIT       (1'b1)
    ) dut_b (
        .C      (C),
        .R      (R),
        .I      (I),
        .T      (T),
        .O      (o_b),
        .VALID  (valid_b),
        .RISE   (rise_b),
        .FALL   (fall_b),
        .GLITCH (glitch_b)
    );

    always #5 C = ~C;

    // Expected outputs packed as {O, VALID, RISE, FALL, GLITCH}.
    typedef struct {
        bit         sel;
        logic [4:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    bit   cur_sel = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(negedge C) begin
        if (sb.size() != 0) begin
            exp_t       item;
            logic [4:0] act;
            item = sb.pop_front();
            act  = item.sel ? {o_b, valid_b, rise_b, fall_b, glitch_b}
                            : {o_a, valid_a, rise_a, fall_a, glitch_a};
            n_checks++;
            if (act !== item.exp) begin
                n_fail++;
                $display("FAIL %s: O/VALID/RISE/FALL/GLITCH got %b expected %b (t=%0t)",
                         item.name, act, item.exp, $time);
            end
        end
    end

    // Apply inputs for the next edge, then after that edge queue what it must produce.
    task automatic step(input logic r, input logic t, input logic i,
                        input logic [4:0] e, input string nm);
        exp_t item;
        R = r;
        T = t;
        I = i;
        @(posedge C);
        #1;
        item.sel  = cur_sel;
        item.exp  = e;
        item.name = nm;
        sb.push_back(item);
    endtask

    task automatic hold(input int n, input logic r, input logic t, input logic i,
                        input logic [4:0] e, input string nm);
        for (int k = 0; k < n; k++) step(r, t, i, e, nm);
    endtask

    initial begin
        int waited;

        // ---- default instance: FILTER_LEN=3, TURN=2, INIT=0 ----
        cur_sel = 1'b0;
        hold(2, 1, 1, 0, 5'b00000, "a_reset");
        hold(2, 0, 1, 0, 5'b00000, "a_turn");
        step(0, 1, 0, 5'b01000, "a_valid_edge3");
        hold(6, 0, 1, 0, 5'b01000, "a_recv_idle");
        // I->1 before edge 10: O rises at edge 14
        hold(4, 0, 1, 1, 5'b01000, "a_rise_pending");
        step(0, 1, 1, 5'b11100, "a_rise_edge14");
        step(0, 1, 1, 5'b11000, "a_rise_done");
        // falling step
        hold(4, 0, 1, 0, 5'b11000, "a_fall_pending");
        step(0, 1, 0, 5'b01010, "a_fall");
        step(0, 1, 0, 5'b01000, "a_fall_done");
        // 2-cycle pulse is rejected with one GLITCH
        hold(2, 0, 1, 1, 5'b01000, "a_glitch_in");
        hold(2, 0, 1, 0, 5'b01000, "a_glitch_pending");
        step(0, 1, 0, 5'b01001, "a_glitch_pulse");
        hold(2, 0, 1, 0, 5'b01000, "a_glitch_after");
        // 3-cycle pulse is exactly long enough: rise then fall
        hold(3, 0, 1, 1, 5'b01000, "a_min_pulse_in");
        step(0, 1, 0, 5'b01000, "a_min_pulse_pending");
        step(0, 1, 0, 5'b11100, "a_min_pulse_rise");
        hold(2, 0, 1, 0, 5'b11000, "a_min_pulse_high");
        step(0, 1, 0, 5'b01010, "a_min_pulse_fall");
        step(0, 1, 0, 5'b01000, "a_min_pulse_done");
        // bring O to 1, then a 1-cycle T=0 drop with I held 1
        hold(4, 0, 1, 1, 5'b01000, "a_setup_high");
        step(0, 1, 1, 5'b11100, "a_setup_rise");
        step(0, 0, 1, 5'b10000, "a_drive_blip");
        hold(2, 0, 1, 1, 5'b10000, "a_blip_turn");
        step(0, 1, 1, 5'b11000, "a_blip_reenter");
        step(0, 1, 1, 5'b11000, "a_blip_recv");
        // T drop, I->0 while driving, T toggles during TURN; re-entry loads 0 silently
        step(0, 0, 0, 5'b10000, "a_tog_drive");
        hold(2, 0, 1, 0, 5'b10000, "a_tog_turn");
        step(0, 0, 0, 5'b10000, "a_tog_back_drive");
        hold(2, 0, 1, 0, 5'b10000, "a_tog_turn2");
        step(0, 1, 0, 5'b01000, "a_tog_reenter");
        step(0, 1, 0, 5'b01000, "a_tog_recv");
        // reset while cnt=2 pending a rise
        hold(4, 0, 1, 1, 5'b01000, "a_rst_pending");
        step(1, 1, 1, 5'b00000, "a_rst_midcount");
        step(0, 1, 1, 5'b00000, "a_rst_turn0");
        step(0, 1, 1, 5'b00000, "a_rst_turn1");
        step(0, 1, 1, 5'b11000, "a_rst_reenter");
        step(0, 1, 1, 5'b11000, "a_rst_recv");

        // ---- FILTER_LEN=1, TURN=1, INIT=1 instance ----
        cur_sel = 1'b1;
        hold(2, 1, 0, 1, 5'b10000, "b_reset_init");
        hold(2, 0, 0, 1, 5'b10000, "b_drive");
        step(0, 1, 1, 5'b10000, "b_turn");
        step(0, 1, 1, 5'b11000, "b_valid_2edges");
        step(0, 1, 1, 5'b11000, "b_recv");
        hold(2, 0, 1, 0, 5'b11000, "b_fall_pending");
        step(0, 1, 0, 5'b01010, "b_fall_edge3");
        step(0, 1, 0, 5'b01000, "b_fall_done");
        hold(2, 0, 1, 1, 5'b01000, "b_rise_pending");
        step(0, 1, 1, 5'b11100, "b_rise_edge3");
        step(0, 1, 1, 5'b11000, "b_rise_done");
        // a 1-cycle low pulse passes a length-1 filter
        step(0, 1, 0, 5'b11000, "b_pulse_in");
        step(0, 1, 1, 5'b11000, "b_pulse_pending");
        step(0, 1, 1, 5'b01010, "b_pulse_fall");
        step(0, 1, 1, 5'b11100, "b_pulse_rise");
        step(0, 1, 1, 5'b11000, "b_pulse_done");

        waited = 0;
        while (sb.size() != 0 && waited < 10) begin
            @(posedge C);
            waited++;
        end
        #2;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibuf_rx_filter.md
IBUF_RX_FILTER -- requirements
Module: ibuf_rx_filter

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 3, meaning the consecutive synchronized cycles a new level must hold before O follows it (legal range 1..15).
REQ-002 SHALL have parameter TURN, default 2, meaning the blanking cycles after the local driver releases the line (legal range 1..15).
REQ-003 SHALL have parameter INIT, default 1'b0, meaning the reset value of the synchronizer and of O.
REQ-004 SHALL have port C, input, 1 bit: the single clock; all flops are rising-edge on C.
REQ-005 SHALL have port R, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port I, input, 1 bit: pad-side line level, asynchronous to C.
REQ-007 SHALL have port T, input, 1 bit: local output-buffer tristate control, synchronous to C; 0 = local driver active, 1 = released.
REQ-008 SHALL have port O, output, 1 bit: filtered received level.
REQ-009 SHALL have port VALID, output, 1 bit: high while in RECV.
REQ-010 SHALL have port RISE, output, 1 bit: one-cycle pulse in the cycle O goes 0->1.
REQ-011 SHALL have port FALL, output, 1 bit: one-cycle pulse in the cycle O goes 1->0.
REQ-012 SHALL have port GLITCH, output, 1 bit: one-cycle pulse when a rejected level change is detected.

Function
REQ-013 SHALL pass I through a two-flop synchronizer s1->s2; only s2 is used downstream.
REQ-014 SHALL implement a 3-state FSM with states DRIVE, TURN and RECV.
REQ-015 DRIVE: VALID=0; O held; filter counter cnt held at 0; RISE/FALL/GLITCH=0; goes to TURN (tcnt=0) on any edge with T=1.
REQ-016 TURN: outputs as in DRIVE; on each edge with T=1, goes to RECV if tcnt==TURN-1, else increments tcnt.
REQ-017 TURN: on an edge with T=0, SHALL return to DRIVE and clear tcnt.
REQ-018 On the TURN->RECV edge, O SHALL load s2 without RISE/FALL/GLITCH, and cnt SHALL clear.
REQ-019 With T held 1, VALID SHALL go high after the (TURN+1)th edge counted from the first edge with T=1.
REQ-020 RECV: on an edge with T=0, SHALL go to DRIVE; O is held, cnt clears, and no pulse is issued on that edge.
REQ-021 RECV filter, per edge: if s2!=O and cnt==FILTER_LEN-1, then O<=s2, cnt<=0, and RISE or FALL pulses per the new value.
REQ-022 RECV filter, per edge: if s2!=O and cnt<FILTER_LEN-1, then cnt<=cnt+1.
REQ-023 RECV filter, per edge: if s2==O and cnt!=0, then GLITCH pulses and cnt<=0.
REQ-024 RECV filter, per edge: if s2==O and cnt==0, there SHALL be no change.
REQ-025 Latency: if I changes and stays stable before edge 1, O SHALL change at edge FILTER_LEN+2 (edge 5 for the default), with RISE/FALL asserted in the same cycle as O changes.
REQ-026 cnt SHALL be 4 bits wide and SHALL never exceed FILTER_LEN-1; no wrap-around.
REQ-027 RISE, FALL and GLITCH SHALL be registered and mutually exclusive, each high for exactly one cycle.
REQ-028 The synchronizer SHALL run in all states, so s2 is current when RECV is entered.

Reset
REQ-029 On an edge with R=1: s1, s2 and O SHALL become INIT; cnt and tcnt SHALL become 0; the state SHALL become DRIVE; VALID, RISE, FALL and GLITCH SHALL become 0.
REQ-030 R SHALL override T and I on the same edge, including reset mid-TURN and mid-filter count; no pulse is issued on or after the reset edge.
REQ-031 After R deasserts with T=1, the TURN sequence SHALL start on the first edge.

Verification
REQ-032 Defaults, R high 2 cycles then low, T=1, I=0: VALID rises after edge 3 and O=0; I->1 before edge 10 gives O=1 with RISE=1 at edge 14, and FALL=0.
REQ-033 In RECV, a 2-cycle I=1 pulse (I=1 at edges 1-2, 0 from edge 3): O stays 0, GLITCH pulses once, RISE never asserts.
REQ-034 In RECV with I=1 held, T=0 for 1 cycle: VALID=0 for TURN+1 cycles; on re-entry O loads s2=1 with no RISE/FALL.
REQ-035 T toggles 1,0,1 during TURN: FSM returns to DRIVE; VALID is delayed to TURN+1 edges after the final rise of T.
REQ-036 R asserted with cnt=2 pending a rise: next cycle O=INIT, cnt=0, state DRIVE, no RISE/FALL/GLITCH.
REQ-037 With FILTER_LEN=1 and TURN=1, an I step: O changes at edge 3; VALID rises 2 edges after T rises.
